// File: rtl/m31_arc_stage.sv
// m31_arc_stage: Add-Round-Constant stage of the Poseidon2 M31 round pipeline.
// Adds the round constants (mod 2^31-1) to the state, tracks round index and
// round type, and carries a {valid, round, full} shadow pipeline matched to the
// downstream x^5 S-box latency.
// Optional feature: define M31_ARC_CANON_CHECK_EN to build the sticky err_o
// flag for lanes equal to 31'h7FFFFFFF; otherwise err_o is tied to 0.

package m31_pkg;
  localparam int M31_ROUNDS = 22;
  localparam int M31_WIDTH  = 16;

  typedef logic [M31_ROUNDS-1:0][M31_WIDTH-1:0][30:0] m31_rc_t;

  // Deterministic generated constant table (all canonical, < 2^31-1).
  // Round 0 lane 0 is 5 and round 0 lane 1 is 0 so wrap-around and zero cases
  // are reachable; swap in the production table without touching the stage.
  function automatic m31_rc_t m31_gen_rc();
    m31_rc_t     tab;
    logic [31:0] x;
    x = 32'h2545F491;
    for (int r = 0; r < M31_ROUNDS; r++) begin
      for (int k = 0; k < M31_WIDTH; k++) begin
        x = x * 32'd1103515245 + 32'd12345;
        tab[r][k] = (x[30:0] == 31'h7FFFFFFF) ? 31'd0 : x[30:0];
      end
    end
    tab[0][0] = 31'd5;
    tab[0][1] = 31'd0;
    return tab;
  endfunction

  localparam m31_rc_t M31_RC = m31_gen_rc();
endpackage

module m31_arc_stage
  import m31_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int RF       = 8,
  parameter int RP       = 14,
  parameter int SBOX_LAT = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 abort_i,
  input  logic                 in_valid_i,
  input  logic [31*WIDTH-1:0]  in_state_i,
  output logic                 out_valid_o,
  output logic [31*WIDTH-1:0]  out_state_o,
  output logic [4:0]           out_round_o,
  output logic                 out_full_o,
  output logic                 sbox_valid_o,
  output logic [4:0]           sbox_round_o,
  output logic                 sbox_full_o,
  output logic                 sbox_last_o,
  output logic                 err_o
);

  localparam int         LW       = 31;
  localparam int         ROUNDS   = RF + RP;
  localparam logic [4:0] FULL_END = 5'(RF / 2);
  localparam logic [4:0] PART_END = 5'(RF / 2 + RP);
  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);
  localparam logic [30:0] P_M31   = 31'h7FFFFFFF;

  // Canonical add mod 2^31-1 of two values in [0, 2^31-1].
  function automatic logic [30:0] m31_add(input logic [30:0] a, input logic [30:0] c);
    logic [31:0] s;
    logic [30:0] t;
    s = {1'b0, a} + {1'b0, c};
    t = s[30:0] + {30'd0, s[31]};
    return (t == P_M31) ? 31'd0 : t;
  endfunction

  logic                accept;
  logic [4:0]          rnd_q, rnd_d;
  logic                full_d;
  logic [LW*WIDTH-1:0] out_state_d;
  logic                out_valid_q;
  logic [LW*WIDTH-1:0] out_state_q;
  logic [4:0]          out_round_q;
  logic                out_full_q;

  logic [SBOX_LAT-1:0] sh_vld_q;
  logic [SBOX_LAT-1:0] sh_full_q;
  logic [4:0]          sh_rnd_q [SBOX_LAT];

  // abort wins over a coincident beat, so the beat is simply not accepted.
  assign accept = in_valid_i & ~abort_i;

  // Round type, next round index and per-lane constant add for the current beat.
  always_comb begin
    logic [30:0] rc;
    rc          = '0;
    full_d      = (rnd_q < FULL_END) || (rnd_q >= PART_END);
    rnd_d       = (rnd_q == LAST_RND) ? 5'd0 : rnd_q + 5'd1;
    out_state_d = '0;
    for (int k = 0; k < WIDTH; k++) begin
      rc = (full_d || k == 0) ? M31_RC[rnd_q][k] : 31'd0;
      out_state_d[LW*k +: LW] = m31_add(in_state_i[LW*k +: LW], rc);
    end
  end

  // Round counter and the registered S-box-input beat; state holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      out_round_q <= '0;
      out_full_q  <= 1'b0;
    end else begin
      out_valid_q <= accept;
      if (abort_i) begin
        rnd_q <= '0;
      end else if (in_valid_i) begin
        rnd_q       <= rnd_d;
        out_state_q <= out_state_d;
        out_round_q <= rnd_q;
        out_full_q  <= full_d;
      end
    end
  end

  // Free-running shadow of {valid, round, full}; abort kills only the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_vld_q  <= '0;
      sh_full_q <= '0;
      for (int i = 0; i < SBOX_LAT; i++) sh_rnd_q[i] <= '0;
    end else begin
      sh_vld_q    <= abort_i ? '0 : {sh_vld_q[SBOX_LAT-2:0], out_valid_q};
      sh_full_q   <= {sh_full_q[SBOX_LAT-2:0], out_full_q};
      sh_rnd_q[0] <= out_round_q;
      for (int i = 1; i < SBOX_LAT; i++) sh_rnd_q[i] <= sh_rnd_q[i-1];
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_state_o  = out_state_q;
  assign out_round_o  = out_round_q;
  assign out_full_o   = out_full_q;
  assign sbox_valid_o = sh_vld_q[SBOX_LAT-1];
  assign sbox_round_o = sh_rnd_q[SBOX_LAT-1];
  assign sbox_full_o  = sh_full_q[SBOX_LAT-1];
  assign sbox_last_o  = sh_vld_q[SBOX_LAT-1] && (sh_rnd_q[SBOX_LAT-1] == LAST_RND);

`ifdef M31_ARC_CANON_CHECK_EN
  logic err_q;
  logic lane_hit;

  // Any lane of the incoming beat holding the non-canonical value p.
  always_comb begin
    lane_hit = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (in_state_i[LW*k +: LW] == P_M31) lane_hit = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (abort_i) begin
      err_q <= 1'b0;
    end else if (in_valid_i && lane_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_m31_arc_stage.sv
// Scoreboard bench for m31_arc_stage: stimulus pushes expected beats computed
// from plain mod-p arithmetic; a negedge monitor pops and compares them.
module tb_m31_arc_stage;
  import m31_pkg::*;

  localparam int    W      = 16;
  localparam int    RF     = 8;
  localparam int    RP     = 14;
  localparam int    L      = 12;
  localparam int    ROUNDS = RF + RP;
  localparam longint P     = 64'h7FFFFFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              abort_i;
  logic              in_valid_i;
  logic [31*W-1:0]   in_state_i;
  logic              out_valid_o;
  logic [31*W-1:0]   out_state_o;
  logic [4:0]        out_round_o;
  logic              out_full_o;
  logic              sbox_valid_o;
  logic [4:0]        sbox_round_o;
  logic              sbox_full_o;
  logic              sbox_last_o;
  logic              err_o;

  m31_arc_stage #(.WIDTH(W), .RF(RF), .RP(RP), .SBOX_LAT(L)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .abort_i      (abort_i),
    .in_valid_i   (in_valid_i),
    .in_state_i   (in_state_i),
    .out_valid_o  (out_valid_o),
    .out_state_o  (out_state_o),
    .out_round_o  (out_round_o),
    .out_full_o   (out_full_o),
    .sbox_valid_o (sbox_valid_o),
    .sbox_round_o (sbox_round_o),
    .sbox_full_o  (sbox_full_o),
    .sbox_last_o  (sbox_last_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  typedef struct { logic [31*W-1:0] st; int rnd; bit full; longint t; } obeat_t;
  typedef struct { int rnd; bit full; longint t; } sbeat_t;
  obeat_t oq[$];
  sbeat_t sq[$];
  longint last_times[$];

  int m_rnd = 0;
  bit m_err = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_full(input int r);
    return (r < RF / 2) || (r >= RF / 2 + RP);
  endfunction

  function automatic logic [30:0] ref_add(input logic [30:0] a, input logic [30:0] c);
    longint s;
    s = (longint'(a) + longint'(c)) % P;
    return s[30:0];
  endfunction

  function automatic logic [31*W-1:0] rand_state();
    logic [31*W-1:0] s;
    for (int k = 0; k < W; k++) s[31*k +: 31] = 31'($urandom_range(32'h7FFFFFFE, 0));
    return s;
  endfunction

  // Drive one cycle at a negedge, then update the reference model just after the edge.
  task automatic step(input bit v, input logic [31*W-1:0] st, input bit ab);
    longint e;
    obeat_t ob;
    sbeat_t sb;
    sbeat_t keep[$];
    in_valid_i = v;
    in_state_i = st;
    abort_i    = ab;
    e = cyc + 1;
    @(posedge clk);
    #1;
    if (ab) begin
      m_rnd = 0;
      m_err = 1'b0;
      foreach (sq[i]) if (sq[i].t < e) keep.push_back(sq[i]);
      sq = keep;
    end else if (v) begin
      ob.rnd  = m_rnd;
      ob.full = is_full(m_rnd);
      ob.t    = e;
      for (int k = 0; k < W; k++) begin
        ob.st[31*k +: 31] = ref_add(st[31*k +: 31],
                                    (ob.full || k == 0) ? M31_RC[m_rnd][k] : 31'd0);
`ifdef M31_ARC_CANON_CHECK_EN
        if (st[31*k +: 31] == 31'h7FFFFFFF) m_err = 1'b1;
`endif
      end
      oq.push_back(ob);
      sb.rnd = m_rnd; sb.full = ob.full; sb.t = e + L;
      sq.push_back(sb);
      m_rnd = (m_rnd + 1) % ROUNDS;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  // Monitor: pops expected beats whenever the DUT presents one.
  always @(negedge clk) begin
    if (mon_en) begin
      while (oq.size() > 0 && oq[0].t < cyc) begin
        chk("out_valid_missing", 0, 1);
        void'(oq.pop_front());
      end
      if (out_valid_o) begin
        if (oq.size() == 0 || oq[0].t != cyc) begin
          chk("out_valid_unexpected", 1, 0);
        end else begin
          obeat_t ob;
          int badlane;
          ob = oq.pop_front();
          badlane = -1;
          for (int k = W - 1; k >= 0; k--)
            if (out_state_o[31*k +: 31] !== ob.st[31*k +: 31]) badlane = k;
          total++;
          if (badlane >= 0) begin
            bad++;
            $display("FAIL out_state lane %0d round %0d: got %0h, expected %0h", badlane, ob.rnd,
                     out_state_o[31*badlane +: 31], ob.st[31*badlane +: 31]);
          end
          chk("out_round", out_round_o, ob.rnd);
          chk("out_full", out_full_o, ob.full);
        end
      end
      while (sq.size() > 0 && sq[0].t < cyc) begin
        chk("sbox_valid_missing", 0, 1);
        void'(sq.pop_front());
      end
      if (sbox_valid_o) begin
        if (sq.size() == 0 || sq[0].t != cyc) begin
          chk("sbox_valid_unexpected", 1, 0);
          chk("sbox_last_idle", sbox_last_o, 0);
        end else begin
          sbeat_t sb;
          sb = sq.pop_front();
          chk("sbox_round", sbox_round_o, sb.rnd);
          chk("sbox_full", sbox_full_o, sb.full);
          chk("sbox_last", sbox_last_o, (sb.rnd == ROUNDS - 1) ? 1 : 0);
        end
      end else begin
        chk("sbox_last_idle", sbox_last_o, 0);
      end
      if (sbox_last_o) last_times.push_back(cyc);
      chk("err", err_o, m_err);
    end
  end

  initial begin
    logic [31*W-1:0] st;
    rst_n      = 1'b0;
    abort_i    = 1'b0;
    in_valid_i = 1'b1;
    in_state_i = rand_state();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_state", (out_state_o == '0) ? 1 : 0, 1);
    chk("rst_out_round", out_round_o, 0);
    chk("rst_out_full", out_full_o, 0);
    chk("rst_sbox_valid", sbox_valid_o, 0);
    chk("rst_sbox_last", sbox_last_o, 0);
    chk("rst_err", err_o, 0);
    in_valid_i = 1'b0;
    rst_n      = 1'b1;
    mon_en     = 1'b1;

    // One permutation of all-zero state: output equals the constants.
    for (int r = 0; r < ROUNDS; r++) begin
      step(1'b1, '0, 1'b0);
      chk("zero_round_idx", out_round_o, r);
    end

    // Boundary adds in round 0: wrap, zero+zero, exact p.
    st = rand_state();
    st[30:0]  = 31'h7FFFFFFE;
    st[61:31] = 31'd0;
    st[92:62] = 31'(P - longint'(M31_RC[0][2]));
    step(1'b1, st, 1'b0);
    chk("wrap_lane0", out_state_o[30:0], 4);
    chk("zero_lane1", out_state_o[61:31], 0);
    chk("exact_p_lane2", out_state_o[92:62], 0);

    // Single isolated beat: scoreboard pins out/sbox valid timing.
    idle(16);
    step(1'b1, rand_state(), 1'b0);
    chk("single_out_valid", out_valid_o, 1);
    idle(16);

    // 44 back-to-back beats from round 0: two end-of-permutation pulses.
    step(1'b0, '0, 1'b1);
    last_times.delete();
    for (int i = 0; i < 44; i++) step(1'b1, rand_state(), 1'b0);
    idle(16);
    chk("last_pulse_count", last_times.size(), 2);
    if (last_times.size() == 2) chk("last_pulse_gap", last_times[1] - last_times[0], 22);

    // Abort mid-permutation with a coincident beat.
    for (int i = 0; i < 8; i++) step(1'b1, rand_state(), 1'b0);
    step(1'b1, rand_state(), 1'b1);
    chk("abort_out_valid", out_valid_o, 0);
    step(1'b1, rand_state(), 1'b0);
    chk("abort_restart_round", out_round_o, 0);
    idle(16);

    // Non-canonical lane and error flag behaviour.
    st = rand_state();
    st[31*3 +: 31] = 31'h7FFFFFFF;
    step(1'b1, st, 1'b0);
`ifdef M31_ARC_CANON_CHECK_EN
    chk("err_set", err_o, 1);
`else
    chk("err_tied", err_o, 0);
`endif
    for (int i = 0; i < 3; i++) step(1'b1, rand_state(), 1'b0);
    step(1'b0, '0, 1'b1);
    chk("err_abort_clear", err_o, 0);

    idle(16);
    chk("out_queue_drained", oq.size(), 0);
    chk("sbox_queue_drained", sq.size(), 0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m31_arc_stage.md
Name: m31_arc_stage

Overview:
- Add-Round-Constant stage of the Poseidon2 M31 round pipeline. Sits directly upstream of the per-lane x^5 S-box array.
- Adds round constants mod p = 2^31-1 to the state and tracks the round index and round type. Full rounds add a constant to every lane; partial rounds add one only to lane 0.
- Also carries a valid/round shadow pipeline matched to the S-box latency, so downstream logic knows when S-box outputs are meaningful.

Parameters:
- WIDTH, 16: number of state lanes (m31_t each).
- RF, 8: number of full rounds. Half at the start of the permutation, half at the end.
- RP, 14: number of partial rounds.
- SBOX_LAT, 12: S-box latency in cycles. Sets the shadow pipeline depth.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- abort_i  in  1  synchronous clear of round tracking and all valid pipelines.
- in_valid_i  in  1  input state beat valid. There is no backpressure; the block accepts every valid beat.
- in_state_i  in  31*WIDTH  input state. Lane k is at bits [31k+30:31k].
- out_valid_o  in/out: out  1  the out_state_o beat is valid (S-box input side).
- out_state_o  out  31*WIDTH  state plus round constants. Drives the S-box inputs directly.
- out_round_o  out  5  round index of the out_state_o beat.
- out_full_o  out  1  1 means full round; 0 means partial round (only lane 0 goes through the S-box).
- sbox_valid_o  out  1  out_valid_o delayed by SBOX_LAT cycles. Aligned with the S-box outputs.
- sbox_round_o  out  5  out_round_o delayed by SBOX_LAT cycles.
- sbox_full_o  out  1  out_full_o delayed by SBOX_LAT cycles.
- sbox_last_o  out  1  marks the S-box output of round RF+RP-1, i.e. the end of the permutation.
- err_o  out  1  non-canonical input flag (see Optional Feature).

Behaviour:
- ROUNDS = RF+RP = 22. Round r is a full round if r < RF/2 or r >= RF/2+RP; otherwise it is a partial round.
- Constants come from the m31_pkg array M31_RC[ROUNDS][WIDTH] and are canonical (< p). Indexing is combinational on the round counter.
- Round counter rnd_q, 5 bits, reset value 0:
  - Increments on each cycle with in_valid_i=1.
  - Wraps from ROUNDS-1 to 0, so permutations are back-to-back with no gap cycle.
- Modular add per lane:
  - s = a + c (32 bits); t = s[30:0] + s[31]; result = (t == 31'h7FFFFFFF) ? 0 : t.
  - The result is always canonical.
  - In a partial round, lanes 1..WIDTH-1 pass through unchanged (constant treated as 0). Lane 0 is added.
- Latency 1 cycle. out_* are registered from the accepted beat, and out_valid_o is registered in_valid_i.
- out_state_o holds its last value when out_valid_o=0. It is not zeroed.
- Shadow pipeline: a SBOX_LAT-deep shift register of {valid, round, full}. It advances every cycle and is not gated by valid.
- sbox_last_o = sbox_valid_o && sbox_round_o == ROUNDS-1.
- abort_i=1:
  - Takes effect on the next edge: rnd_q <= 0, out_valid_o <= 0, every shadow valid bit <= 0.
  - The data and round fields of the shadow may retain stale values.
  - abort_i and in_valid_i in the same cycle: abort wins and the beat is dropped.
- Reset (async, mid-operation included): all outputs 0, rnd_q = 0, and all shadow stages cleared immediately.
- Inputs are required to be canonical. Lane value 31'h7FFFFFFF is handled by the add (it is treated as 0 mod p) and produces a canonical sum.

Optional Feature:
- Macro: M31_ARC_CANON_CHECK_EN.
- Enabled:
  - err_o is sticky. It sets on the edge after an accepted beat in which any lane equals 31'h7FFFFFFF.
  - It is cleared only by reset or abort_i.
- Disabled: err_o is tied to 0, and no comparison logic is built.

Test Plan:
- Reset, then 22 valid beats with all lanes 0:
  - out_state_o equals the M31_RC[r] lanes for full rounds.
  - For partial rounds r=4..17, out_state_o has lane0 = M31_RC[r][0] and other lanes 0.
  - out_round_o steps 0..21.
  - out_full_o = 1 only for rounds 0-3 and 18-21.
- Lane 0 = 31'h7FFFFFFE with constant 5 -> lane0 = 4. Lane value 0 with constant 0 -> 0. Sum exactly equal to p -> 0.
- Single valid beat at cycle T:
  - out_valid_o = 1 at T+1.
  - sbox_valid_o = 1 at exactly T+1+12 and 0 in every other cycle.
- 44 consecutive beats:
  - The round counter wraps 21->0 with no gap.
  - sbox_last_o pulses twice, 22 cycles apart.
- abort_i asserted with in_valid_i after round 7:
  - The beat is dropped and out_valid_o = 0 next cycle.
  - The next beat is round 0.
  - No sbox_valid_o pulse appears from in-flight beats.
- With M31_ARC_CANON_CHECK_EN, feed lane 3 = 31'h7FFFFFFF:
  - err_o = 1 from the next cycle and stays set.
  - abort_i clears it.
  - Without the macro, err_o stays 0.
